// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [5:0]  OP_HALT    = 6'b111111;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - combinational next-PC selection (sequential, branch, jump)
module next_pc_gen (
    input  logic [31:0] pcplus4,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] next_pc
);

    // Word offset of the branch immediate, sign-extended and scaled to bytes.
    logic [31:0] branch_off;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Jump overrides branch; both targets keep the low two bits at zero.
    always_comb begin
        next_pc = pcplus4;
        if (jump) begin
            next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pcplus4 + branch_off;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC register, imem handshake and instruction hold for decode
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             halted,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired_count
);

    // The wait counter only has to reach TIMEOUT-1.
    localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             instr_valid_q;
    logic             halted_q;
    logic             fetch_err_q;
    logic [CNT_W-1:0] retired_q;
    logic [TMO_W-1:0] tmo_q;
    logic [31:0]      next_pc;
    logic             is_halt_op;

    assign is_halt_op    = (instr_q[31:26] == OP_HALT);
    assign pcplus4       = pc_q + WORD_BYTES;
    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = instr_valid_q;
    assign halted        = halted_q;
    assign fetch_err     = fetch_err_q;
    assign retired_count = retired_q;

    next_pc_gen u_next_pc_gen (
        .pcplus4      (pcplus4),
        .instr        (instr_q),
        .branch_taken (branch_taken),
        .jump         (jump),
        .next_pc      (next_pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and the one-cycle request strobe.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = !reset;
                state_d  = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = HALT;
                end
            end
            ISSUE: begin
                if (is_halt_op) begin
                    state_d = HALT;
                end else if (instr_ready) begin
                    state_d = FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Datapath: capture response, count wait cycles, retire and advance PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
            retired_q     <= '0;
            tmo_q         <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    tmo_q <= '0;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        fetch_err_q <= 1'b1;
                        halted_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ISSUE: begin
                    if (is_halt_op) begin
                        instr_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else if (instr_ready) begin
                        retired_q     <= retired_q + CNT_W'(1);
                        instr_valid_q <= 1'b0;
                        pc_q          <= next_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TMO    = 4;
    localparam int          CW     = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_rvalid = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [31:0]   pcplus4;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic          jump = 1'b0;
    logic          halted;
    logic          fetch_err;
    logic [CW-1:0] retired_count;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .pc            (pc),
        .pcplus4       (pcplus4),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .halted        (halted),
        .fetch_err     (fetch_err),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Architectural next-PC rule written as plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic br, input logic jp);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if (br) begin
            off = int'(word & 32'h0000_FFFF);
            if (off >= 32768) off = off - 65536;
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b1; imem_rvalid = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pc !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (halted !== 1'b0 || fetch_err !== 1'b0) begin failures++; $display("FAIL rst_flags halted=%b err=%b exp=0/0", halted, fetch_err); end
        checks++; if (retired_count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", retired_count); end
        exp_pc  = RST_PC;
        exp_cnt = 32'd0;
        reset   = 1'b0;
        #1;
    endtask

    // Drives one complete fetch/issue/retire transaction; entered and left in the FETCH cycle.
    task automatic run_instr(input logic [31:0] word, input int lat, input int stall,
                             input logic br, input logic jp);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL fetch_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== exp_pc) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", imem_addr, exp_pc); end
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL wait_idle req=%b valid=%b exp=0/0", imem_req, instr_valid); end
            imem_rvalid = (i == lat - 1);
            imem_rdata  = (i == lat - 1) ? word : $urandom;
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL issue_valid got=%b exp=1", instr_valid); end
        checks++; if (instr !== word) begin failures++; $display("FAIL issue_instr got=%h exp=%h", instr, word); end
        checks++; if (pc !== exp_pc || pcplus4 !== exp_pc + 32'd4) begin failures++; $display("FAIL issue_pc pc=%h pc4=%h exp=%h", pc, pcplus4, exp_pc); end
        for (int s = 0; s < stall; s++) begin
            instr_ready  = 1'b0;
            branch_taken = 1'($urandom);
            jump         = 1'($urandom);
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== word || pc !== exp_pc || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold valid=%b instr=%h pc=%h req=%b exp=1/%h/%h/0", instr_valid, instr, pc, imem_req, word, exp_pc);
            end
            checks++; if (retired_count !== exp_cnt) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", retired_count, exp_cnt); end
        end
        instr_ready  = 1'b1;
        branch_taken = br;
        jump         = jp;
        @(negedge clk);
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        exp_pc  = model_next(exp_pc, word, br, jp);
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (retired_count !== exp_cnt) begin failures++; $display("FAIL retire_count got=%0d exp=%0d", retired_count, exp_cnt); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL retire_valid got=%b exp=0", instr_valid); end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_sequential();
        int t0;
        do_reset();
        t0 = cycle;
        for (int k = 0; k < 3; k++) run_instr(32'h2000_0000 + 32'(k), 1, 0, 1'b0, 1'b0);
        checks++; if (cycle - t0 !== 9) begin failures++; $display("FAIL seq_cycles got=%0d exp=9", cycle - t0); end
        checks++; if (retired_count !== 32'd3) begin failures++; $display("FAIL seq_count got=%0d exp=3", retired_count); end
        checks++; if (imem_addr !== 32'h10C) begin failures++; $display("FAIL seq_addr got=%h exp=10c", imem_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(32'h1000_FFFF, 1, 0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL branch_back got=%h exp=100", imem_addr); end
        run_instr(32'h1000_0003, 1, 0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 32'h110) begin failures++; $display("FAIL branch_fwd got=%h exp=110", imem_addr); end
    endtask

    task automatic test_jump();
        do_reset();
        run_instr(32'h0800_0040, 1, 0, 1'b1, 1'b1);
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL jump_prio got=%h exp=100", imem_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_instr(rand_word(), 2, 5, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL bp_addr got=%h exp=104", imem_addr); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        run_instr(32'h1000_FFBE, 1, 0, 1'b1, 1'b0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
        run_instr(rand_word(), 1, 0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%h exp=0", imem_addr); end
    endtask

    task automatic test_timeout();
        do_reset();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL tmo_req got=%b exp=1", imem_req); end
        imem_rvalid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            checks++; if (fetch_err !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL tmo_early err=%b halted=%b exp=0/0 wait=%0d", fetch_err, halted, i); end
        end
        @(negedge clk);
        checks++; if (fetch_err !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL tmo_err err=%b halted=%b exp=1/1", fetch_err, halted); end
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            instr_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b0 || fetch_err !== 1'b1 || retired_count !== '0) begin
                failures++;
                $display("FAIL tmo_absorb valid=%b req=%b err=%b cnt=%0d exp=0/0/1/0", instr_valid, imem_req, fetch_err, retired_count);
            end
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_timeout_edge();
        do_reset();
        run_instr(rand_word(), TMO, 0, 1'b0, 1'b0);
        checks++; if (fetch_err !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL tmo_edge err=%b halted=%b exp=0/0", fetch_err, halted); end
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(rand_word(), 1, 0, 1'b0, 1'b0);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL halt_req got=%b exp=1", imem_req); end
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFC00_0000;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hFC00_0000) begin failures++; $display("FAIL halt_issue valid=%b instr=%h exp=1/fc000000", instr_valid, instr); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_early got=%b exp=0", halted); end
        instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin failures++; $display("FAIL halt_state halted=%b valid=%b err=%b exp=1/0/0", halted, instr_valid, fetch_err); end
        checks++; if (retired_count !== exp_cnt) begin failures++; $display("FAIL halt_count got=%0d exp=%0d", retired_count, exp_cnt); end
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            jump        = 1'($urandom);
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== exp_pc) begin failures++; $display("FAIL halt_absorb req=%b valid=%b pc=%h exp=0/0/%h", imem_req, instr_valid, pc, exp_pc); end
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        jump        = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        run_instr(rand_word(), 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (pc !== RST_PC || retired_count !== '0) begin failures++; $display("FAIL midrst_pc pc=%h cnt=%0d exp=%h/0", pc, retired_count, RST_PC); end
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL midrst_flags valid=%b req=%b halted=%b exp=0/0/0", instr_valid, imem_req, halted); end
        exp_pc  = RST_PC;
        exp_cnt = 32'd0;
        reset   = 1'b0;
        #1;
        run_instr(rand_word(), 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            run_instr(rand_word(), $urandom_range(1, TMO), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));
        end
        checks++; if (retired_count !== 32'd40) begin failures++; $display("FAIL rand_count got=%0d exp=40", retired_count); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_backpressure();
        test_pc_wrap();
        test_timeout();
        test_timeout_edge();
        test_halt();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
